// File: rtl/rx_deser.sv
// UART receive deserializer: collects DATA_WIDTH data bits from the baud
// sampler's mid-bit strobes and checks the optional parity bit and the stop
// bit(s). Each completed word is presented with a single-cycle valid pulse.
module rx_deser #(
    parameter int DATA_WIDTH = 8,
    parameter int MSB_FIRST  = 0,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rx_rst,
    input  logic                  start,
    input  logic                  enable,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Strobe counts at which the data and stop phases end.
    localparam logic [3:0] LAST_BIT  = 4'(DATA_WIDTH - 1);
    localparam logic [1:0] LAST_STOP = 2'(STOP_BITS - 1);
    localparam logic       PODD      = (PARITY_ODD != 0);
    localparam logic       PEN       = (PARITY_EN != 0);

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] shreg_reg, shreg_next;
    logic [3:0]            bit_cnt_reg, bit_cnt_next;
    logic [1:0]            stop_cnt_reg, stop_cnt_next;
    logic                  perr_reg, perr_next;
    logic                  ferr_reg, ferr_next;
    logic [DATA_WIDTH-1:0] data_out_reg, data_out_next;
    logic                  data_valid_reg, data_valid_next;
    logic                  parity_err_reg, parity_err_next;
    logic                  frame_err_reg, frame_err_next;

    // Shift register contents after taking in the current rx sample.
    logic [DATA_WIDTH-1:0] shift_in;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_shift
            if (MSB_FIRST != 0) begin : g_msb
                // First bit received ends up in the top position.
                if (gi == 0) begin : g_edge
                    assign shift_in[gi] = rx;
                end else begin : g_mid
                    assign shift_in[gi] = shreg_reg[gi-1];
                end
            end else begin : g_lsb
                // First bit received ends up in bit 0.
                if (gi == DATA_WIDTH - 1) begin : g_edge
                    assign shift_in[gi] = rx;
                end else begin : g_mid
                    assign shift_in[gi] = shreg_reg[gi+1];
                end
            end
        end
    endgenerate

    // Framing FSM: next state, datapath updates and completion outputs.
    always_comb begin
        state_next      = state_reg;
        shreg_next      = shreg_reg;
        bit_cnt_next    = bit_cnt_reg;
        stop_cnt_next   = stop_cnt_reg;
        perr_next       = perr_reg;
        ferr_next       = ferr_reg;
        data_out_next   = data_out_reg;
        data_valid_next = 1'b0;
        parity_err_next = 1'b0;
        frame_err_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                // enable is deliberately ignored here; only start arms a frame.
                if (start) begin
                    state_next   = DATA;
                    bit_cnt_next = 4'd0;
                    shreg_next   = '0;
                    perr_next    = 1'b0;
                    ferr_next    = 1'b0;
                end
            end
            DATA: begin
                if (enable) begin
                    shreg_next   = shift_in;
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg == LAST_BIT) begin
                        state_next    = PEN ? PARITY : STOP;
                        stop_cnt_next = 2'd0;
                    end
                end
            end
            PARITY: begin
                if (enable) begin
                    perr_next     = ((^shreg_reg) ^ rx) != PODD;
                    state_next    = STOP;
                    stop_cnt_next = 2'd0;
                end
            end
            STOP: begin
                if (enable) begin
                    ferr_next     = ferr_reg | ~rx;
                    stop_cnt_next = stop_cnt_reg + 2'd1;
                    if (stop_cnt_reg == LAST_STOP) begin
                        // A start in this same cycle is dropped; the sampler re-issues it.
                        state_next      = IDLE;
                        data_out_next   = shreg_reg;
                        data_valid_next = 1'b1;
                        parity_err_next = PEN & perr_reg;
                        frame_err_next  = ferr_reg | ~rx;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rx_rst) begin
            state_reg      <= IDLE;
            shreg_reg      <= '0;
            bit_cnt_reg    <= 4'd0;
            stop_cnt_reg   <= 2'd0;
            perr_reg       <= 1'b0;
            ferr_reg       <= 1'b0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shreg_reg      <= shreg_next;
            bit_cnt_reg    <= bit_cnt_next;
            stop_cnt_reg   <= stop_cnt_next;
            perr_reg       <= perr_next;
            ferr_reg       <= ferr_next;
            data_out_reg   <= data_out_next;
            data_valid_reg <= data_valid_next;
            parity_err_reg <= parity_err_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign parity_err = parity_err_reg;
    assign frame_err  = frame_err_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_rx_deser.sv
// Bench for rx_deser: four instances in different framing configurations,
// directed frames plus randomized frames against a word-level model.
module tb_rx_deser;

    logic       clk;
    logic       rx_rst;
    logic [3:0] start_v;
    logic [3:0] enable_v;
    logic [3:0] rx_v;
    logic [3:0] dv_v;
    logic [3:0] pe_v;
    logic [3:0] fe_v;
    logic [3:0] busy_v;
    logic [7:0] dout_a, dout_b, dout_c;
    logic [4:0] dout_d;

    int checks = 0;
    int errors = 0;

    // Configuration of each instance: width, msb-first, parity enable, odd, stop bits.
    int cfg_w    [4] = '{8, 8, 8, 5};
    int cfg_msb  [4] = '{0, 0, 0, 1};
    int cfg_pen  [4] = '{0, 1, 1, 0};
    int cfg_podd [4] = '{0, 0, 1, 0};
    int cfg_stop [4] = '{1, 1, 2, 1};

    rx_deser #(.DATA_WIDTH(8), .MSB_FIRST(0), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rx_rst(rx_rst), .start(start_v[0]), .enable(enable_v[0]), .rx(rx_v[0]),
        .data_out(dout_a), .data_valid(dv_v[0]), .parity_err(pe_v[0]), .frame_err(fe_v[0]), .busy(busy_v[0]));
    rx_deser #(.DATA_WIDTH(8), .MSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_b (
        .clk(clk), .rx_rst(rx_rst), .start(start_v[1]), .enable(enable_v[1]), .rx(rx_v[1]),
        .data_out(dout_b), .data_valid(dv_v[1]), .parity_err(pe_v[1]), .frame_err(fe_v[1]), .busy(busy_v[1]));
    rx_deser #(.DATA_WIDTH(8), .MSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_c (
        .clk(clk), .rx_rst(rx_rst), .start(start_v[2]), .enable(enable_v[2]), .rx(rx_v[2]),
        .data_out(dout_c), .data_valid(dv_v[2]), .parity_err(pe_v[2]), .frame_err(fe_v[2]), .busy(busy_v[2]));
    rx_deser #(.DATA_WIDTH(5), .MSB_FIRST(1), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_d (
        .clk(clk), .rx_rst(rx_rst), .start(start_v[3]), .enable(enable_v[3]), .rx(rx_v[3]),
        .data_out(dout_d), .data_valid(dv_v[3]), .parity_err(pe_v[3]), .frame_err(fe_v[3]), .busy(busy_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] get_dout(input int idx);
        case (idx)
            0:       return {1'b0, dout_a};
            1:       return {1'b0, dout_b};
            2:       return {1'b0, dout_c};
            3:       return {4'b0, dout_d};
            default: return '0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one frame to instance idx and check the completion against the model.
    //   flip      : invert the correct parity bit
    //   stops     : stops[0] is the first stop bit, stops[1] the second
    //   en_start  : raise enable together with start (must not shift a bit)
    //   extra     : pulse start again during the data bits (must be ignored)
    //   end_start : raise start with the final stop strobe (must not be taken)
    task automatic send_frame(input int idx, input logic [8:0] data, input bit flip,
                              input logic [1:0] stops, input bit en_start, input bit extra,
                              input bit end_start, input int gap_max);
        bit         bits[$];
        int         w;
        int         ones;
        bit         pbit;
        logic [8:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
        w        = cfg_w[idx];
        exp_data = data & ((9'd1 << w) - 9'd1);
        ones     = 0;
        for (int k = 0; k < w; k++) begin
            bits.push_back(cfg_msb[idx] != 0 ? exp_data[w-1-k] : exp_data[k]);
            ones += int'(exp_data[k]);
        end
        exp_pe = 1'b0;
        if (cfg_pen[idx] != 0) begin
            pbit = bit'((ones % 2) != cfg_podd[idx]) ^ flip;
            bits.push_back(pbit);
            exp_pe = (((ones + int'(pbit)) % 2) != cfg_podd[idx]);
        end
        exp_fe = 1'b0;
        for (int s = 0; s < cfg_stop[idx]; s++) begin
            bits.push_back(stops[s]);
            if (stops[s] == 1'b0) exp_fe = 1'b1;
        end

        start_v[idx]  = 1'b1;
        enable_v[idx] = en_start;
        rx_v[idx]     = 1'($urandom);
        @(negedge clk);
        start_v[idx]  = 1'b0;
        enable_v[idx] = 1'b0;
        check($sformatf("busy_armed[%0d]", idx), {8'b0, busy_v[idx]}, 9'd1);

        for (int k = 0; k < bits.size(); k++) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            if (k == bits.size() - 1)
                check($sformatf("dv_early[%0d]", idx), {8'b0, dv_v[idx]}, 9'd0);
            rx_v[idx]     = bits[k];
            enable_v[idx] = 1'b1;
            if (extra && k == 1) start_v[idx] = 1'b1;
            if (end_start && k == bits.size() - 1) start_v[idx] = 1'b1;
            @(negedge clk);
            enable_v[idx] = 1'b0;
            start_v[idx]  = 1'b0;
            rx_v[idx]     = 1'($urandom);
        end

        check($sformatf("dv[%0d]", idx), {8'b0, dv_v[idx]}, 9'd1);
        check($sformatf("data[%0d]", idx), get_dout(idx), exp_data);
        check($sformatf("perr[%0d]", idx), {8'b0, pe_v[idx]}, {8'b0, exp_pe});
        check($sformatf("ferr[%0d]", idx), {8'b0, fe_v[idx]}, {8'b0, exp_fe});
        check($sformatf("busy_done[%0d]", idx), {8'b0, busy_v[idx]}, 9'd0);
        @(negedge clk);
        check($sformatf("dv_pulse[%0d]", idx), {8'b0, dv_v[idx]}, 9'd0);
        check($sformatf("errs_clear[%0d]", idx), {7'b0, pe_v[idx], fe_v[idx]}, 9'd0);
        check($sformatf("data_hold[%0d]", idx), get_dout(idx), exp_data);
        check($sformatf("busy_idle[%0d]", idx), {8'b0, busy_v[idx]}, 9'd0);
        $display("frame inst=%0d data=%0h flip=%0b stops=%0b -> dout=%0h pe=%0b fe=%0b",
                 idx, exp_data, flip, stops, get_dout(idx), exp_pe, exp_fe);
    endtask

    initial begin
        rx_rst   = 1'b1;
        start_v  = '0;
        enable_v = '0;
        rx_v     = '1;
        repeat (3) @(negedge clk);
        rx_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_data[%0d]", i), get_dout(i), 9'd0);
            check($sformatf("rst_flags[%0d]", i), {5'b0, dv_v[i], pe_v[i], fe_v[i], busy_v[i]}, 9'd0);
        end

        // enable strobes while idle do nothing
        for (int k = 0; k < 3; k++) begin
            rx_v[0] = 1'b0; enable_v[0] = 1'b1;
            @(negedge clk);
            enable_v[0] = 1'b0;
        end
        check("idle_enable_busy", {8'b0, busy_v[0]}, 9'd0);
        check("idle_enable_dv", {8'b0, dv_v[0]}, 9'd0);

        // basic LSB-first word
        send_frame(0, 9'h0A5, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 0);
        // even parity: correct then wrong parity bit
        send_frame(1, 9'h00F, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1);
        send_frame(1, 9'h00F, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1);
        // two stop bits: second stop low, then both high
        send_frame(2, 9'h03C, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1);
        send_frame(2, 9'h03C, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1);
        // first stop low also flags
        send_frame(2, 9'h0C3, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 0);

        // reset in the middle of a frame discards it
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rx_v[0] = 1'b1; enable_v[0] = 1'b1;
            @(negedge clk);
            enable_v[0] = 1'b0;
        end
        rx_rst = 1'b1;
        @(negedge clk);
        rx_rst = 1'b0;
        check("midrst_busy", {8'b0, busy_v[0]}, 9'd0);
        check("midrst_data", get_dout(0), 9'd0);
        check("midrst_flags", {6'b0, dv_v[0], pe_v[0], fe_v[0]}, 9'd0);
        send_frame(0, 9'h081, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 0);

        // MSB-first 5-bit word with extra start pulses mid-frame
        send_frame(3, 9'b10011, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1);

        // back-to-back frames, next start right after the valid cycle
        send_frame(0, 9'h055, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 0);
        send_frame(0, 9'h0AA, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);
        check("b2b_hold", get_dout(0), 9'h0AA);

        // start coincident with final stop strobe is not taken
        send_frame(1, 9'h05A, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1);
        // enable with start in idle does not shift a bit
        send_frame(3, 9'b01101, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1);

        // randomized frames on every configuration
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 4; i++) begin
                send_frame(i, 9'($urandom), ($urandom_range(0, 3) == 0),
                           ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11,
                           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                           bit'($urandom_range(0, 1)), 2);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
